// File: rtl/sand_row_engine.sv
// sand_row_engine: streaming falling-sand update over a region/floor row pair.
// Words enter in order. Each word is processed once its right-hand neighbour has
// arrived, or against a WALL edge at the end of the row. Updated words then leave
// through a single registered output slot.
module sand_row_engine #(
    parameter int CELLS    = 16,
    parameter int WORDS    = 40,
    parameter int SPOUT_LO = 18,
    parameter int SPOUT_HI = 21
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_odd,
    input  logic               row_spout,
    input  logic               row_bottom,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*CELLS-1:0] in_region,
    input  logic [2*CELLS-1:0] in_floor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*CELLS-1:0] out_region,
    output logic [2*CELLS-1:0] out_floor
);
    localparam int W  = 2 * CELLS;
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST_W = IW'(WORDS - 1);
    localparam logic [1:0] AIR = 2'b00, SAND = 2'b01, SAND_AM = 2'b10, WALL = 2'b11;

    typedef enum logic [1:0] {EMPTY, ONE, RUN, FLUSH} state_t;

    state_t        state;
    logic          flush_tail;            // FLUSH: P already emitted, only C's result remains
    logic [W-1:0]  p_region, p_floor;     // processed, awaiting output
    logic [W-1:0]  c_region, c_floor;     // awaiting processing
    logic [IW-1:0] cidx;                  // word index held in C
    logic          odd_q, spout_q, bottom_q;

    logic [W-1:0]  n_floor, pr_region, pr_floor;
    logic [1:0]    fl [CELLS+2];          // floor seen by C: left neighbour, C's cells, right neighbour
    logic [1:0]    rc, nr;
    logic [31:0]   col;
    logic          spout_here, slot, accept;

    // Process C: a left-to-right sweep over its cells. Each cell sees the floor as
    // already modified by the cells to its left, including P's last floor cell.
    always_comb begin
        n_floor    = (((state == EMPTY) ? row_bottom : bottom_q) != 1'b0) ? '1 : in_floor;
        spout_here = spout_q && (int'(cidx) >= SPOUT_LO) && (int'(cidx) <= SPOUT_HI);
        pr_region  = c_region;
        pr_floor   = c_floor;
        rc         = AIR;
        nr         = AIR;
        col        = '0;
        for (int k = 0; k < CELLS + 2; k++) fl[k] = WALL;
        if (cidx != '0) fl[0] = p_floor[1:0];
        if (state != FLUSH) fl[CELLS+1] = n_floor[W-1 -: 2];
        for (int j = 0; j < CELLS; j++) fl[j+1] = c_floor[2*(CELLS-j)-1 -: 2];
        for (int j = 0; j < CELLS; j++) begin
            rc  = c_region[2*(CELLS-j)-1 -: 2];
            nr  = rc;
            col = 32'(cidx) * 32'(CELLS) + 32'(j);
            if (rc == SAND_AM) begin
                nr = SAND;
            end else if (rc == SAND) begin
                if (fl[j+1] == AIR) begin
                    nr = AIR;
                    fl[j+1] = SAND_AM;
                end else if (fl[j] == AIR && fl[j+2] == AIR) begin
                    // Tie-break alternates with column and frame parity, so there is no drift.
                    nr = AIR;
                    if ((col[0] ^ odd_q) != 1'b0) fl[j+2] = SAND_AM;
                    else                          fl[j]   = SAND_AM;
                end else if (fl[j] == AIR) begin
                    nr = AIR;
                    fl[j] = SAND_AM;
                end else if (fl[j+2] == AIR) begin
                    nr = AIR;
                    fl[j+2] = SAND_AM;
                end
            end
            if (spout_here && nr == AIR) nr = SAND;
            pr_region[2*(CELLS-j)-1 -: 2] = nr;
        end
        for (int j = 0; j < CELLS; j++) pr_floor[2*(CELLS-j)-1 -: 2] = fl[j+1];
    end

    // Handshake qualifiers. RUN accepts only when the output slot can take P.
    always_comb begin
        slot = !out_valid || out_ready;
        case (state)
            EMPTY, ONE: in_ready = 1'b1;
            RUN:        in_ready = slot;
            default:    in_ready = 1'b0;
        endcase
        accept = in_valid && in_ready;
    end

    // Row sequencer: shift N->C->P->output and latch the row sideband with word 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            flush_tail <= 1'b0;
            p_region   <= '0;
            p_floor    <= '0;
            c_region   <= '0;
            c_floor    <= '0;
            cidx       <= '0;
            odd_q      <= 1'b0;
            spout_q    <= 1'b0;
            bottom_q   <= 1'b0;
            out_valid  <= 1'b0;
            out_region <= '0;
            out_floor  <= '0;
        end else begin
            if (out_ready) out_valid <= 1'b0;
            case (state)
                EMPTY: if (accept) begin
                    c_region <= in_region;
                    c_floor  <= n_floor;
                    cidx     <= '0;
                    odd_q    <= frame_odd;
                    spout_q  <= row_spout;
                    bottom_q <= row_bottom;
                    state    <= ONE;
                end
                ONE: if (accept) begin
                    p_region   <= pr_region;
                    p_floor    <= pr_floor;
                    c_region   <= in_region;
                    c_floor    <= {fl[CELLS+1], n_floor[W-3:0]};
                    cidx       <= cidx + IW'(1);
                    flush_tail <= 1'b0;
                    state      <= (WORDS == 2) ? FLUSH : RUN;
                end
                RUN: if (accept) begin
                    out_region <= p_region;
                    out_floor  <= {p_floor[W-1:2], fl[0]};
                    out_valid  <= 1'b1;
                    p_region   <= pr_region;
                    p_floor    <= pr_floor;
                    c_region   <= in_region;
                    c_floor    <= {fl[CELLS+1], n_floor[W-3:0]};
                    cidx       <= cidx + IW'(1);
                    flush_tail <= 1'b0;
                    if (cidx + IW'(1) == LAST_W) state <= FLUSH;
                end
                default: if (slot) begin
                    out_valid <= 1'b1;
                    if (!flush_tail) begin
                        out_region <= p_region;
                        out_floor  <= {p_floor[W-1:2], fl[0]};
                        p_region   <= pr_region;
                        p_floor    <= pr_floor;
                        flush_tail <= 1'b1;
                    end else begin
                        out_region <= p_region;
                        out_floor  <= p_floor;
                        flush_tail <= 1'b0;
                        cidx       <= '0;
                        state      <= EMPTY;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sand_row_engine.sv
// Bench for sand_row_engine. A whole-row reference model fills a queue of expected
// words, which are popped at each output handshake. Directed rows cover the
// physics corners, backpressure, mid-row reset and throughput.
module tb_sand_row_engine;
    localparam int CELLS = 4;
    localparam int WORDS = 3;
    localparam int SP_LO = 1;
    localparam int SP_HI = 1;
    localparam int W     = 2 * CELLS;
    localparam int NC    = CELLS * WORDS;

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] f;
    } wd_t;

    logic         clk, reset_n, frame_odd, row_spout, row_bottom;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_region, in_floor, out_region, out_floor;

    sand_row_engine #(.CELLS(CELLS), .WORDS(WORDS), .SPOUT_LO(SP_LO), .SPOUT_HI(SP_HI)) dut (
        .clk(clk), .reset_n(reset_n), .frame_odd(frame_odd), .row_spout(row_spout),
        .row_bottom(row_bottom), .in_valid(in_valid), .in_ready(in_ready),
        .in_region(in_region), .in_floor(in_floor), .out_valid(out_valid),
        .out_ready(out_ready), .out_region(out_region), .out_floor(out_floor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wd_t          exp_q[$];
    logic [W-1:0] rin [WORDS];
    logic [W-1:0] fin [WORDS];
    logic [W-1:0] got_r [WORDS];
    logic [W-1:0] got_f [WORDS];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: the whole row as one flat cell array, swept left to right.
    task automatic model_row(input logic odd, input logic sp, input logic bot);
        logic [1:0] r [NC];
        logic [1:0] f [NC];
        logic [1:0] l, rr;
        wd_t        e;
        for (int c = 0; c < NC; c++) begin
            r[c] = rin[c / CELLS][2*(CELLS-(c % CELLS))-1 -: 2];
            f[c] = bot ? 2'b11 : fin[c / CELLS][2*(CELLS-(c % CELLS))-1 -: 2];
        end
        for (int c = 0; c < NC; c++) begin
            l  = 2'b11;
            rr = 2'b11;
            if (c > 0)      l  = f[c-1];
            if (c < NC - 1) rr = f[c+1];
            if (r[c] == 2'b10) begin
                r[c] = 2'b01;
            end else if (r[c] == 2'b01) begin
                if (f[c] == 2'b00) begin
                    r[c] = 2'b00; f[c] = 2'b10;
                end else if (l == 2'b00 && rr == 2'b00) begin
                    r[c] = 2'b00;
                    if (((c % 2) ^ int'(odd)) == 0) f[c-1] = 2'b10;
                    else                             f[c+1] = 2'b10;
                end else if (l == 2'b00) begin
                    r[c] = 2'b00; f[c-1] = 2'b10;
                end else if (rr == 2'b00) begin
                    r[c] = 2'b00; f[c+1] = 2'b10;
                end
            end
        end
        for (int c = 0; c < NC; c++)
            if (sp && (c / CELLS) >= SP_LO && (c / CELLS) <= SP_HI && r[c] == 2'b00) r[c] = 2'b01;
        for (int w = 0; w < WORDS; w++) begin
            for (int j = 0; j < CELLS; j++) begin
                e.r[2*(CELLS-j)-1 -: 2] = r[w*CELLS+j];
                e.f[2*(CELLS-j)-1 -: 2] = f[w*CELLS+j];
            end
            exp_q.push_back(e);
        end
    endtask

    // Streams rin/fin as one row. ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    task automatic run_row(input logic odd, input logic sp, input logic bot,
                           input int ready_mode, input bit gap, output int first, output int last);
        int           ni = 0, no = 0, budget = 0;
        bit           stalled = 0;
        logic [2*W-1:0] held = '0;
        wd_t          e;
        first = 0;
        last  = 0;
        model_row(odd, sp, bot);
        while ((ni < WORDS || no < WORDS) && budget < 200) begin
            in_valid  = (ni < WORDS) && (!gap || $urandom_range(3) != 0);
            in_region = '0;
            in_floor  = '0;
            if (ni < WORDS) begin
                in_region = rin[ni];
                in_floor  = fin[ni];
            end
            frame_odd  = odd;
            row_spout  = sp;
            row_bottom = bot;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (budget % 4 == 0) || (budget % 4 == 3);
                default: out_ready = 1'($urandom_range(1));
            endcase
            #1;
            if (stalled) begin
                chk("stall_valid", 64'(out_valid), 64'(1));
                chk("stall_data", 64'({out_region, out_floor}), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 64'(exp_q.size()), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("w%0d_region", no), 64'(out_region), 64'(e.r));
                    chk($sformatf("w%0d_floor", no), 64'(out_floor), 64'(e.f));
                end
                if (no < WORDS) begin
                    got_r[no] = out_region;
                    got_f[no] = out_floor;
                end
                no++;
                last = cyc;
            end
            stalled = out_valid && !out_ready;
            held    = {out_region, out_floor};
            if (in_valid && in_ready) begin
                if (ni == 0) first = cyc;
                ni++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            budget++;
        end
        in_valid = 1'b0;
        chk("row_inputs", 64'(ni), 64'(WORDS));
        chk("row_outputs", 64'(no), 64'(WORDS));
    endtask

    task automatic set_row(input logic [W-1:0] r0, r1, r2, f0, f1, f2);
        rin[0] = r0; rin[1] = r1; rin[2] = r2;
        fin[0] = f0; fin[1] = f1; fin[2] = f2;
    endtask

    // Directed sequence.
    initial begin
        int first, last;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        frame_odd = 1'b0; row_spout = 1'b0; row_bottom = 1'b0;
        in_region = '0; in_floor = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_region", 64'(out_region), 64'(0));
        chk("rst_out_floor", 64'(out_floor), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Straight fall into AIR; full rate gives WORDS+2 cycles per row.
        set_row(8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        run_row(0, 0, 0, 0, 0, first, last);
        chk("fall_region", 64'(got_r[0]), 64'(8'h00));
        chk("fall_floor", 64'(got_f[0]), 64'(8'h80));
        chk("row_cycles", 64'(last - first), 64'(WORDS + 2));

        // Diagonal move across the word 0 / word 1 boundary.
        set_row(8'h01, 8'h00, 8'h00, 8'hFF, 8'h3F, 8'hFF);
        run_row(0, 0, 0, 0, 0, first, last);
        chk("xb_region0", 64'(got_r[0]), 64'(8'h00));
        chk("xb_floor1", 64'(got_f[1]), 64'(8'hBF));

        // Tie-break at c=5 on both frame parities.
        set_row(8'h00, 8'h10, 8'h00, 8'hFF, 8'h33, 8'hFF);
        run_row(0, 0, 0, 0, 0, first, last);
        chk("tie_even_floor1", 64'(got_f[1]), 64'(8'h3B));
        run_row(1, 0, 0, 0, 0, first, last);
        chk("tie_odd_floor1", 64'(got_f[1]), 64'(8'hB3));

        // Row edges: the outside neighbour is WALL, so nothing moves.
        set_row(8'h40, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF);
        run_row(0, 0, 0, 0, 0, first, last);
        chk("edge_region0", 64'(got_r[0]), 64'(8'h40));
        chk("edge_region2", 64'(got_r[2]), 64'(8'h01));

        // Off-screen floor becomes all WALL.
        set_row(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        run_row(0, 0, 1, 0, 0, first, last);
        for (int w = 0; w < WORDS; w++) chk($sformatf("bottom_floor%0d", w), 64'(got_f[w]), 64'(8'hFF));

        // Spout fills AIR in word 1 only.
        set_row(8'h00, 8'h1C, 8'h00, 8'hFF, 8'hFF, 8'hFF);
        run_row(0, 1, 0, 0, 0, first, last);
        chk("spout_w0", 64'(got_r[0]), 64'(8'h00));
        chk("spout_w1", 64'(got_r[1]), 64'(8'h5D));
        chk("spout_w2", 64'(got_r[2]), 64'(8'h00));

        // Backpressure pattern, then random rows with input gaps and random stalls.
        set_row(8'h45, 8'h14, 8'h91, 8'h0C, 8'h30, 8'h03);
        run_row(0, 0, 0, 1, 0, first, last);
        run_row(1, 0, 0, 1, 1, first, last);
        for (int t = 0; t < 8; t++) begin
            for (int w = 0; w < WORDS; w++) begin
                rin[w] = 8'($urandom);
                fin[w] = 8'($urandom);
            end
            run_row(1'($urandom_range(1)), 1'($urandom_range(1)), (t == 3), 2, 1, first, last);
        end

        // Mid-row reset with a stalled output word in flight.
        out_ready = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            in_valid  = 1'b1;
            in_region = 8'h55;
            in_floor  = 8'h00;
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'(0));
        chk("stalled_valid", 64'(out_valid), 64'(1));
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        chk("midrst_out_region", 64'(out_region), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);
        set_row(8'h50, 8'h05, 8'h40, 8'h00, 8'hC0, 8'h3C);
        run_row(0, 0, 0, 0, 0, first, last);

        // Nothing left over once the stream drains.
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("idle_out_valid", 64'(out_valid), 64'(0));
        chk("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
